// File: rtl/mips_mem_wb_pipe_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// MemRead/MemWrite are requests held until MemReady; MemRData is valid with MemReady.
interface mips_mem_wb_pipe_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemRData;
  logic              MemReady;

  modport master (
    output MemAddr, MemWData, MemRead, MemWrite,
    input  MemRData, MemReady
  );

  modport slave (
    input  MemAddr, MemWData, MemRead, MemWrite,
    output MemRData, MemReady
  );
endinterface

// File: rtl/mips_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers around the data-memory access stage.
// Define MEM_STALL_EN to honour MemReady and stall EX with a RUN/WAIT FSM;
// without it every access completes in one cycle and StallEX is tied low.
module mips_mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ValidEX,
  input  logic                 FlushEX,
  input  logic                 RegWriteEX,
  input  logic                 MemtoRegEX,
  input  logic                 MemReadEX,
  input  logic                 MemWriteEX,
  input  logic [REG_W-1:0]     WriteRegEX,
  input  logic [DATA_W-1:0]    ALUResultEX,
  input  logic [DATA_W-1:0]    WriteDataEX,
  mips_mem_wb_pipe_if.master   mem,
  output logic                 RegWriteMEM,
  output logic [REG_W-1:0]     WriteRegMEM,
  output logic [DATA_W-1:0]    ALUResultMEM,
  output logic                 RegWriteWB,
  output logic [REG_W-1:0]     WriteRegWB,
  output logic [DATA_W-1:0]    ResultWB,
  output logic                 StallEX
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] result;
  } mem_wb_t;

  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    mem_req;
  logic    stall_ex;

  // Qualified memory requests and bus outputs, straight from the EX/MEM register
  assign mem.MemRead  = ex_mem_q.valid & ex_mem_q.mem_read;
  assign mem.MemWrite = ex_mem_q.valid & ex_mem_q.mem_write;
  assign mem.MemAddr  = ex_mem_q.alu_result;
  assign mem.MemWData = ex_mem_q.write_data;
  assign mem_req      = mem.MemRead | mem.MemWrite;

`ifdef MEM_STALL_EN
  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;
  state_t state_q, state_d;

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next-state and stall: stall whenever a request is outstanding without MemReady
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    state_d  = state_q;
    stall_ex = mem_req & ~mem.MemReady;
    case (state_q)
      S_RUN:   if (mem_req && !mem.MemReady) state_d = S_WAIT;
      S_WAIT:  if (mem.MemReady)             state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end
`else
  // Single-cycle memory: MemReady is not consulted and EX never stalls
  logic unused_mem_ready;
  assign unused_mem_ready = mem.MemReady;
  assign stall_ex         = 1'b0;
`endif

  assign StallEX = stall_ex;

  // EX/MEM next value: hold while stalled, otherwise load (flush makes a bubble)
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall_ex) begin
      ex_mem_d.valid      = ValidEX & ~FlushEX;
      ex_mem_d.reg_write  = RegWriteEX;
      ex_mem_d.mem_to_reg = MemtoRegEX;
      ex_mem_d.mem_read   = MemReadEX;
      ex_mem_d.mem_write  = MemWriteEX;
      ex_mem_d.write_reg  = WriteRegEX;
      ex_mem_d.alu_result = ALUResultEX;
      ex_mem_d.write_data = WriteDataEX;
    end
  end

  // MEM/WB next value: bubble while stalled, otherwise the completed MEM result
  always_comb begin
    mem_wb_d.valid     = ex_mem_q.valid & ~stall_ex;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.write_reg = ex_mem_q.write_reg;
    mem_wb_d.result    = ex_mem_q.mem_to_reg ? mem.MemRData : ex_mem_q.alu_result;
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign RegWriteMEM  = ex_mem_q.valid & ex_mem_q.reg_write;
  assign WriteRegMEM  = ex_mem_q.write_reg;
  assign ALUResultMEM = ex_mem_q.alu_result;
  assign RegWriteWB   = mem_wb_q.valid & mem_wb_q.reg_write;
  assign WriteRegWB   = mem_wb_q.write_reg;
  assign ResultWB     = mem_wb_q.result;

endmodule

// File: tb/tb_mips_mem_wb_pipe.sv
// Directed bench for mips_mem_wb_pipe; stall scenarios run when MEM_STALL_EN is defined.
module tb_mips_mem_wb_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidEX, FlushEX, RegWriteEX, MemtoRegEX, MemReadEX, MemWriteEX;
  logic [4:0]  WriteRegEX;
  logic [31:0] ALUResultEX, WriteDataEX;
  logic        RegWriteMEM, RegWriteWB, StallEX;
  logic [4:0]  WriteRegMEM, WriteRegWB;
  logic [31:0] ALUResultMEM, ResultWB;
  int          checks = 0;
  int          errors = 0;

  mips_mem_wb_pipe_if #(.DATA_W(32)) bus ();

  mips_mem_wb_pipe #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ValidEX(ValidEX), .FlushEX(FlushEX), .RegWriteEX(RegWriteEX),
    .MemtoRegEX(MemtoRegEX), .MemReadEX(MemReadEX), .MemWriteEX(MemWriteEX),
    .WriteRegEX(WriteRegEX), .ALUResultEX(ALUResultEX), .WriteDataEX(WriteDataEX),
    .mem(bus),
    .RegWriteMEM(RegWriteMEM), .WriteRegMEM(WriteRegMEM), .ALUResultMEM(ALUResultMEM),
    .RegWriteWB(RegWriteWB), .WriteRegWB(WriteRegWB), .ResultWB(ResultWB),
    .StallEX(StallEX)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ValidEX = 0; FlushEX = 0; RegWriteEX = 0; MemtoRegEX = 0;
    MemReadEX = 0; MemWriteEX = 0; WriteRegEX = '0; ALUResultEX = '0; WriteDataEX = '0;
  endtask

  initial begin
    // 1: reset with random inputs for two edges
    rst_n = 0;
    ValidEX = 1; FlushEX = 0; RegWriteEX = 1; MemtoRegEX = $urandom;
    MemReadEX = 1; MemWriteEX = 1; WriteRegEX = 5'($urandom);
    ALUResultEX = $urandom; WriteDataEX = $urandom;
    bus.MemRData = $urandom; bus.MemReady = 0;
    tick(); tick();
    check("rst_regwrite_mem", 32'(RegWriteMEM), 0);
    check("rst_writereg_mem", 32'(WriteRegMEM), 0);
    check("rst_alu_mem", ALUResultMEM, 0);
    check("rst_regwrite_wb", 32'(RegWriteWB), 0);
    check("rst_writereg_wb", 32'(WriteRegWB), 0);
    check("rst_result_wb", ResultWB, 0);
    check("rst_memread", 32'(bus.MemRead), 0);
    check("rst_memwrite", 32'(bus.MemWrite), 0);
    check("rst_memaddr", bus.MemAddr, 0);
    check("rst_stall", 32'(StallEX), 0);
    clear_ex();
    bus.MemRData = 32'hFFFF_FFFF;
    rst_n = 1;
    tick();

    // 2: ADD r3 = 0x10
    ValidEX = 1; RegWriteEX = 1; WriteRegEX = 5'd3; ALUResultEX = 32'h10;
    tick(); clear_ex();
    check("add_regwrite_mem", 32'(RegWriteMEM), 1);
    check("add_writereg_mem", 32'(WriteRegMEM), 3);
    check("add_alu_mem", ALUResultMEM, 32'h10);
    check("add_memread", 32'(bus.MemRead), 0);
    tick();
    check("add_regwrite_wb", 32'(RegWriteWB), 1);
    check("add_writereg_wb", 32'(WriteRegWB), 3);
    check("add_result_wb", ResultWB, 32'h10);
    check("add_mem_bubble", 32'(RegWriteMEM), 0);

    // 4: flushed r7 write becomes a bubble
    ValidEX = 1; FlushEX = 1; RegWriteEX = 1; WriteRegEX = 5'd7; ALUResultEX = 32'h77;
    tick(); clear_ex();
    check("flush_regwrite_mem", 32'(RegWriteMEM), 0);
    tick();
    check("flush_regwrite_wb", 32'(RegWriteWB), 0);

    // Store with immediate ready: RegWrite=0 reaches WB
    ValidEX = 1; MemWriteEX = 1; ALUResultEX = 32'h40; WriteDataEX = 32'h1234; WriteRegEX = 5'd9;
    bus.MemReady = 1;
    tick(); clear_ex();
    check("sw_memwrite", 32'(bus.MemWrite), 1);
    check("sw_memaddr", bus.MemAddr, 32'h40);
    check("sw_memwdata", bus.MemWData, 32'h1234);
    check("sw_stall", 32'(StallEX), 0);
    tick();
    bus.MemReady = 0;
    check("sw_regwrite_wb", 32'(RegWriteWB), 0);
    check("sw_memwrite_drop", 32'(bus.MemWrite), 0);

`ifdef MEM_STALL_EN
    // MemReady without a request is ignored
    bus.MemReady = 1; #1;
    check("idle_ready_stall", 32'(StallEX), 0);
    bus.MemReady = 0;

    // 3: LW r5 with two wait cycles
    ValidEX = 1; RegWriteEX = 1; MemtoRegEX = 1; MemReadEX = 1;
    WriteRegEX = 5'd5; ALUResultEX = 32'h80; bus.MemRData = 32'hDEAD_BEEF;
    tick(); clear_ex(); #1;
    check("lw_stall_c1", 32'(StallEX), 1);
    check("lw_memread_c1", 32'(bus.MemRead), 1);
    tick();
    check("lw_stall_c2", 32'(StallEX), 1);
    check("lw_wb_bubble_c2", 32'(RegWriteWB), 0);
    check("lw_hold_writereg", 32'(WriteRegMEM), 5);
    tick();
    check("lw_wb_bubble_c3", 32'(RegWriteWB), 0);
    bus.MemReady = 1; #1;
    check("lw_stall_release", 32'(StallEX), 0);
    tick();
    bus.MemReady = 0;
    check("lw_result_wb", ResultWB, 32'hDEAD_BEEF);
    check("lw_writereg_wb", 32'(WriteRegWB), 5);
    check("lw_regwrite_wb", 32'(RegWriteWB), 1);
    check("lw_memread_done", 32'(bus.MemRead), 0);

    // 5: stalled SW aborted by reset
    ValidEX = 1; MemWriteEX = 1; ALUResultEX = 32'h44; WriteDataEX = 32'h55;
    tick(); clear_ex();
    tick();
    check("swrst_memwrite_wait", 32'(bus.MemWrite), 1);
    check("swrst_stall_wait", 32'(StallEX), 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("swrst_memwrite", 32'(bus.MemWrite), 0);
    check("swrst_stall", 32'(StallEX), 0);
`else
    // 6: LW with MemReady low completes in one cycle, no stall
    ValidEX = 1; RegWriteEX = 1; MemtoRegEX = 1; MemReadEX = 1;
    WriteRegEX = 5'd5; ALUResultEX = 32'h80; bus.MemRData = 32'hCAFE_F00D; bus.MemReady = 0;
    tick(); clear_ex(); #1;
    check("lw1_memread", 32'(bus.MemRead), 1);
    check("lw1_stall", 32'(StallEX), 0);
    tick();
    check("lw1_result_wb", ResultWB, 32'hCAFE_F00D);
    check("lw1_writereg_wb", 32'(WriteRegWB), 5);
    check("lw1_regwrite_wb", 32'(RegWriteWB), 1);
    check("lw1_memread_pulse", 32'(bus.MemRead), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
